// File: rtl/i2c_ball_slave.sv
`timescale 1ns/1ps
// i2c_ball_slave
//   Write-only I2C target that receives the 3-byte ball-handoff frame
//   {ball_y[9:8],6'b0}, ball_y[7:0], ball_vy from the peer board's master.
//   The block never stretches SCL and only ever pulls SDA low to ACK.
// Ports
//   clk_i        system clock (single domain)
//   rst_ni       asynchronous active-low reset
//   scl_i        I2C clock from the peer master (asynchronous)
//   sda_io       I2C data; driven 0 for ACK, otherwise released (z)
//   ball_y_o     last committed ball Y position
//   ball_vy_o    last committed ball Y velocity
//   ball_valid_o 1-clk pulse when a new frame is committed
//   frame_err_o  1-clk pulse when an addressed frame is discarded
//   busy_o       high from an address-matched START until STOP / re-START
module i2c_ball_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    inout  wire        sda_io,
    output logic [9:0] ball_y_o,
    output logic [7:0] ball_vy_o,
    output logic       ball_valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_WAIT_STOP
    } state_e;

    // Synchronizers reset to 1 (idle bus) so leaving reset creates no edges.
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_hist_q, sda_hist_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_io};
            scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
            sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

    state_e     state_q, state_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] byte_in;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [1:0] bytecnt_q, bytecnt_d;       // saturates at 3
    logic [1:0] byte0_q, byte0_d;           // only ball_y[9:8] of byte0 is kept
    logic [7:0] byte1_q, byte1_d, byte2_q, byte2_d;
    logic       ovf_q, ovf_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic [9:0] ball_y_q, ball_y_d;
    logic [7:0] ball_vy_q, ball_vy_d;
    logic       valid_q, valid_d, err_q, err_d;

    assign byte_in = {shift_q, sda_s};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bitcnt_q  <= '0;
            bytecnt_q <= '0;
            byte0_q   <= '0;
            byte1_q   <= '0;
            byte2_q   <= '0;
            ovf_q     <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            ball_y_q  <= '0;
            ball_vy_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            bytecnt_q <= bytecnt_d;
            byte0_q   <= byte0_d;
            byte1_q   <= byte1_d;
            byte2_q   <= byte2_d;
            ovf_q     <= ovf_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            ball_y_q  <= ball_y_d;
            ball_vy_q <= ball_vy_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        bytecnt_d = bytecnt_q;
        byte0_d   = byte0_q;
        byte1_d   = byte1_q;
        byte2_d   = byte2_q;
        ovf_d     = ovf_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        ball_y_d  = ball_y_q;
        ball_vy_d = ball_vy_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        if (start_det) begin
            // (Repeated) START: drop whatever was in flight, judge the new frame alone.
            err_d     = busy_q;
            busy_d    = 1'b0;
            oe_d      = 1'b0;
            state_d   = S_ADDR;
            bitcnt_d  = '0;
            bytecnt_d = '0;
            ovf_d     = 1'b0;
        end else if (stop_det) begin
            if (busy_q) begin
                if (bytecnt_q == 2'd3 && !ovf_q) begin
                    ball_y_d  = {byte0_q, byte1_q};
                    ball_vy_d = byte2_q;
                    valid_d   = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            busy_d  = 1'b0;
            oe_d    = 1'b0;
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_WAIT_STOP: ;
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d  = byte_in[6:0];
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            if (byte_in[7:1] == SLAVE_ADDR && !byte_in[0]) begin
                                state_d = S_ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = S_WAIT_STOP;
                            end
                        end
                    end
                end
                // First SCL fall after bit 8 starts the ACK, the next one ends it.
                S_ADDR_ACK, S_DATA_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d     = 1'b0;
                            state_d  = S_DATA;
                            bitcnt_d = '0;
                        end
                    end
                end
                S_DATA: begin
                    if (scl_rise) begin
                        shift_d  = byte_in[6:0];
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            if (bytecnt_q != 2'd3) begin
                                case (bytecnt_q)
                                    2'd0:    byte0_d = byte_in[7:6];
                                    2'd1:    byte1_d = byte_in;
                                    default: byte2_d = byte_in;
                                endcase
                                bytecnt_d = bytecnt_q + 2'd1;
                                state_d   = S_DATA_ACK;
                            end else begin
                                ovf_d   = 1'b1;
                                state_d = S_WAIT_STOP;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Bus conditions release SDA combinationally, without waiting a clock.
    assign sda_io       = (oe_q && !start_det && !stop_det) ? 1'b0 : 1'bz;
    assign ball_y_o     = ball_y_q;
    assign ball_vy_o    = ball_vy_q;
    assign ball_valid_o = valid_q;
    assign frame_err_o  = err_q;
    assign busy_o       = busy_q;
endmodule

// File: tb/tb_i2c_ball_slave.sv
`timescale 1ns/1ps
module tb_i2c_ball_slave;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_rel = 1'b1;
    wire        sda;
    logic [9:0] ball_y;
    logic [7:0] ball_vy;
    logic       ball_valid, frame_err, busy;

    pullup (sda);
    assign sda = sda_rel ? 1'bz : 1'b0;

    always #5 clk = ~clk;

    i2c_ball_slave #(.SLAVE_ADDR(7'h3C), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .scl_i(scl), .sda_io(sda),
        .ball_y_o(ball_y), .ball_vy_o(ball_vy), .ball_valid_o(ball_valid),
        .frame_err_o(frame_err), .busy_o(busy)
    );

    typedef struct { bit err; logic [9:0] y; logic [7:0] vy; } exp_t;
    exp_t exp_q[$];
    int n_chk = 0, n_pass = 0;
    int h = 200;           // SCL half period in ns
    bit busy_seen = 0;
    logic [9:0] model_y = '0;
    logic [7:0] model_vy = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic void push_valid(input logic [9:0] y, input logic [7:0] vy);
        exp_t e;
        e.err = 1'b0; e.y = y; e.vy = vy;
        model_y = y; model_vy = vy;
        exp_q.push_back(e);
    endfunction

    function automatic void push_err();
        exp_t e;
        e.err = 1'b1; e.y = model_y; e.vy = model_vy;
        exp_q.push_back(e);
    endfunction

    // Output monitor: every valid/err pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (busy) busy_seen = 1'b1;
        if (ball_valid || frame_err) begin
            chk("vld_err_excl", {31'b0, ball_valid & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_evt", {30'b0, ball_valid, frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("evt_kind", {31'b0, frame_err}, {31'b0, e.err});
                chk("evt_y", {22'b0, ball_y}, {22'b0, e.y});
                chk("evt_vy", {24'b0, ball_vy}, {24'b0, e.vy});
            end
        end
    end

    task automatic i2c_start();
        sda_rel = 1'b1; #(h/2); scl = 1'b1; #(h); sda_rel = 1'b0; #(h); scl = 1'b0; #(h/2);
    endtask

    task automatic i2c_stop();
        sda_rel = 1'b0; #(h/2); scl = 1'b1; #(h); sda_rel = 1'b1; #(h);
    endtask

    task automatic send_bit(input bit b);
        sda_rel = b; #(h/2); scl = 1'b1; #(h); scl = 1'b0; #(h/2);
    endtask

    task automatic get_ack(output bit a);
        sda_rel = 1'b1; #(h/2); scl = 1'b1; #(h/2); a = sda; #(h/2); scl = 1'b0; #(h/2);
    endtask

    task automatic send_chk(input string tag, input logic [7:0] b, input bit exp_ack);
        bit a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        get_ack(a);
        chk(tag, {31'b0, a}, {31'b0, exp_ack});
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        chk(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_y", {22'b0, ball_y}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_sda", {31'b0, sda}, 32'd1);
        #50 rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Full frame at 100 kHz
        h = 5000;
        i2c_start();
        send_chk("t1_ack_addr", 8'h78, 1'b0);
        #1 chk("t1_busy", {31'b0, busy}, 32'd1);
        send_chk("t1_ack_b0", 8'hC0, 1'b0);
        send_chk("t1_ack_b1", 8'h5A, 1'b0);
        send_chk("t1_ack_b2", 8'h07, 1'b0);
        push_valid(10'h35A, 8'h07);
        i2c_stop();
        wait_drain("t1_drain");
        chk("t1_y", {22'b0, ball_y}, 32'h35A);
        chk("t1_busy_off", {31'b0, busy}, 32'd0);
        h = 200;

        // Other address: ignored entirely
        busy_seen = 0;
        i2c_start();
        send_chk("t2_nack_addr", 8'hA0, 1'b1);
        send_chk("t2_nack_b0", 8'h11, 1'b1);
        send_chk("t2_nack_b1", 8'h22, 1'b1);
        send_chk("t2_nack_b2", 8'h33, 1'b1);
        i2c_stop();
        wait_drain("t2_drain");
        chk("t2_busy_seen", {31'b0, busy_seen}, 32'd0);
        chk("t2_y", {22'b0, ball_y}, {22'b0, model_y});

        // Read request: NACK
        busy_seen = 0;
        i2c_start();
        send_chk("t3_nack_rd", 8'h79, 1'b1);
        i2c_stop();
        wait_drain("t3_drain");
        chk("t3_busy_seen", {31'b0, busy_seen}, 32'd0);
        chk("t3_vy", {24'b0, ball_vy}, {24'b0, model_vy});

        // Short frame
        i2c_start();
        send_chk("t4_ack_addr", 8'h78, 1'b0);
        send_chk("t4_ack_b0", 8'h80, 1'b0);
        send_chk("t4_ack_b1", 8'h99, 1'b0);
        push_err();
        i2c_stop();
        wait_drain("t4_drain");

        // Overflow: 4th byte NACKed
        i2c_start();
        send_chk("t5_ack_addr", 8'h78, 1'b0);
        send_chk("t5_ack_b0", 8'h40, 1'b0);
        send_chk("t5_ack_b1", 8'h01, 1'b0);
        send_chk("t5_ack_b2", 8'h02, 1'b0);
        send_chk("t5_nack_b3", 8'h03, 1'b1);
        push_err();
        i2c_stop();
        wait_drain("t5_drain");

        // Repeated START after one byte, then a full frame
        i2c_start();
        send_chk("t6_ack_addr", 8'h78, 1'b0);
        send_chk("t6_ack_p0", 8'h11, 1'b0);
        push_err();
        i2c_start();
        send_chk("t6_ack_addr2", 8'h78, 1'b0);
        send_chk("t6_ack_b0", 8'h40, 1'b0);
        send_chk("t6_ack_b1", 8'h10, 1'b0);
        send_chk("t6_ack_b2", 8'hFE, 1'b0);
        push_valid(10'h110, 8'hFE);
        i2c_stop();
        wait_drain("t6_drain");
        chk("t6_y", {22'b0, ball_y}, 32'h110);

        // Reset while the target holds the ACK low
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h78 >> i));
        sda_rel = 1'b1;
        #20;
        chk("t7_ack_drv", {31'b0, sda}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_sda", {31'b0, sda}, 32'd1);
        chk("t7_rst_y", {22'b0, ball_y}, 32'd0);
        chk("t7_rst_vy", {24'b0, ball_vy}, 32'd0);
        chk("t7_rst_busy", {31'b0, busy}, 32'd0);
        model_y = '0; model_vy = '0;
        #50 scl = 1'b1;
        #200 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        i2c_start();
        send_chk("t7_ack_addr", 8'h78, 1'b0);
        send_chk("t7_ack_b0", 8'h80, 1'b0);
        send_chk("t7_ack_b1", 8'h33, 1'b0);
        send_chk("t7_ack_b2", 8'h44, 1'b0);
        push_valid(10'h233, 8'h44);
        i2c_stop();
        wait_drain("t7_drain");
        chk("t7_y", {22'b0, ball_y}, 32'h233);
        chk("t7_vy", {24'b0, ball_vy}, 32'h44);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
